// File: rtl/dci_reset_ctrl_if.sv
// Handshake bundle between the DCI reset sequencer and its environment.
// The slave side is the sequencer; the master side drives start/locked.
`timescale 1ns/1ps

interface dci_reset_ctrl_if;
    logic       start;      // single-cycle (re)calibration request
    logic       locked;     // raw LOCKED from the DCIRESET wrapper
    logic       dci_rst;    // wrapper reset, active high
    logic       ready;      // calibrated and lock stable
    logic       busy;       // sequence in progress
    logic       error;      // sticky: every attempt timed out
    logic       lock_lost;  // sticky: lock dropped while ready
    logic [3:0] retries;    // timeouts in the current sequence

    modport master (
        output start, locked,
        input  dci_rst, ready, busy, error, lock_lost, retries
    );

    modport slave (
        input  start, locked,
        output dci_rst, ready, busy, error, lock_lost, retries
    );
endinterface

// File: rtl/dci_reset_ctrl.sv
// DCI reset sequencer: pulses the DCIRESET wrapper reset, waits for a stable
// LOCKED with a timeout, retries a bounded number of times, and recalibrates
// automatically when lock is lost. 'ready' gates the DDR3 PHY bring-up.
`timescale 1ns/1ps

module dci_reset_ctrl #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    dci_reset_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_READY,
        ST_FAIL
    } state_e;

    // Terminal counts: a counter that starts at 0 on state entry spends
    // exactly N cycles in the state when it leaves at N-1.
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic        sync1_q, sync2_q;
    logic        locked_sync;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] stable_q, stable_d;
    logic [3:0]  retries_q, retries_d;
    logic        error_q, error_d;
    logic        lock_lost_q, lock_lost_d;
    logic        dci_rst_q, ready_q, busy_q;

    // Two-flop synchronizer for the asynchronous LOCKED input.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.locked;
            sync2_q <= sync1_q;
        end
    end

    assign locked_sync = sync2_q;

    // Next-state and counter logic for the calibration sequence.
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        stable_d    = '0;
        retries_d   = retries_q;
        error_d     = error_q;
        lock_lost_d = lock_lost_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (AUTO_START || bus.start) state_d = ST_ASSERT;
            end

            ST_ASSERT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_LOCK: begin
                stable_d = locked_sync ? stable_q + 16'd1 : '0;
                // A stable lock wins over a timeout landing on the same cycle.
                if (locked_sync && (stable_q == STABLE_LAST)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d     = '0;
                    retries_d = (retries_q == 4'hF) ? retries_q : retries_q + 4'd1;
                    if (retries_q < RETRY_LIMIT) begin
                        state_d = ST_ASSERT;
                    end else begin
                        state_d = ST_FAIL;
                        error_d = 1'b1;
                    end
                end
            end

            ST_READY: begin
                cnt_d = '0;
                // Lock loss and start collapse into one recalibration.
                if (!locked_sync || bus.start) begin
                    state_d   = ST_ASSERT;
                    retries_d = '0;
                    if (!locked_sync) lock_lost_d = 1'b1;
                end
            end

            ST_FAIL: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d   = ST_ASSERT;
                    error_d   = 1'b0;
                    retries_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; outputs decode the next state
    // so they change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stable_q    <= '0;
            retries_q   <= '0;
            error_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            dci_rst_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retries_q   <= retries_d;
            error_q     <= error_d;
            lock_lost_q <= lock_lost_d;
            dci_rst_q   <= (state_d == ST_ASSERT);
            ready_q     <= (state_d == ST_READY);
            busy_q      <= (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK);
        end
    end

    assign bus.dci_rst   = dci_rst_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.retries   = retries_q;

endmodule

// File: tb/tb_dci_reset_ctrl.sv
// Self-checking bench for dci_reset_ctrl. DUT A auto-starts and walks through
// lock-up, lock loss, timeouts/FAIL, glitch qualification and async reset via
// a stimulus table; DUT B (AUTO_START=0) covers start gating by hand.
`timescale 1ns/1ps

module tb_dci_reset_ctrl;

    typedef struct packed {
        logic       dci_rst;
        logic       ready;
        logic       busy;
        logic       error;
        logic       lock_lost;
        logic [3:0] retries;
    } obs_t;

    typedef struct {
        string name;
        int    cycles;
        logic  start;
        logic  locked;
        obs_t  exp;
    } vec_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_t;

    logic clk;
    logic rst_a_n, rst_b_n;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    sb_t  sb_q[$];

    dci_reset_ctrl_if if_a ();
    dci_reset_ctrl_if if_b ();

    dci_reset_ctrl #(
        .RST_CYCLES(16), .TIMEOUT_CYCLES(100), .STABLE_CYCLES(8),
        .MAX_RETRIES(2), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(if_a)
    );

    dci_reset_ctrl #(
        .RST_CYCLES(16), .TIMEOUT_CYCLES(100), .STABLE_CYCLES(8),
        .MAX_RETRIES(2), .AUTO_START(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic dci, input logic rdy, input logic bsy,
                                input logic err, input logic ll, input int ret);
        obs_t o;
        o.dci_rst   = dci;
        o.ready     = rdy;
        o.busy      = bsy;
        o.error     = err;
        o.lock_lost = ll;
        o.retries   = 4'(ret);
        return o;
    endfunction

    function automatic obs_t get_obs(input bit sel_b);
        if (sel_b)
            return {if_b.dci_rst, if_b.ready, if_b.busy, if_b.error, if_b.lock_lost, if_b.retries};
        return {if_a.dci_rst, if_a.ready, if_a.busy, if_a.error, if_a.lock_lost, if_a.retries};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got dci_rst=%b ready=%b busy=%b error=%b lock_lost=%b retries=%0d, want dci_rst=%b ready=%b busy=%b error=%b lock_lost=%b retries=%0d",
                     name, act.dci_rst, act.ready, act.busy, act.error, act.lock_lost, act.retries,
                     exp.dci_rst, exp.ready, exp.busy, exp.error, exp.lock_lost, exp.retries);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input int cyc, input logic st, input logic lk,
                           input logic dci, input logic rdy, input logic bsy,
                           input logic err, input logic ll, input int ret);
        vec_t v;
        v.name   = name;
        v.cycles = cyc;
        v.start  = st;
        v.locked = lk;
        v.exp    = mk(dci, rdy, bsy, err, ll, ret);
        vecs.push_back(v);
    endtask

    // Length in cycles of the next dci_rst pulse, sampled on negedges; the
    // pulse must begin within 50 cycles.
    task automatic pulse_len(input bit sel_b, output int len);
        int n;
        n   = 0;
        len = 0;
        while (!get_obs(sel_b).dci_rst && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (get_obs(sel_b).dci_rst && len < 200) begin
            len++;
            @(negedge clk);
        end
    endtask

    // ready and dci_rst must never be high together.
    always @(negedge clk) begin
        if (rst_a_n && if_a.ready && if_a.dci_rst)
            check_val("a_ready_with_dci_rst", 1, 0);
        if (rst_b_n && if_b.ready && if_b.dci_rst)
            check_val("b_ready_with_dci_rst", 1, 0);
    end

    initial begin
        sb_t e;
        int  len;
        int  n;

        // Timeline of DUT A, counted in negedges Nk after reset release at N0.
        //        name              cyc st lk  dci rdy bsy err ll ret
        add_vec("idle_after_rel",    0, 0, 0,  0,  0,  0,  0,  0, 0);
        add_vec("assert_first",      1, 0, 0,  1,  0,  1,  0,  0, 0);
        add_vec("assert_last",      15, 0, 0,  1,  0,  1,  0,  0, 0);
        add_vec("wait_entry",        1, 0, 0,  0,  0,  1,  0,  0, 0);
        add_vec("wait_no_lock",     20, 0, 0,  0,  0,  1,  0,  0, 0);
        add_vec("wait_locking",      9, 0, 1,  0,  0,  1,  0,  0, 0);
        add_vec("ready_rise",        1, 0, 1,  0,  1,  0,  0,  0, 0);
        add_vec("glitch_in_sync",    1, 0, 0,  0,  1,  0,  0,  0, 0);
        add_vec("glitch_seen",       1, 0, 1,  0,  1,  0,  0,  0, 0);
        add_vec("lost_reassert",     1, 0, 1,  1,  0,  1,  0,  1, 0);
        add_vec("lost_assert_end",  15, 0, 1,  1,  0,  1,  0,  1, 0);
        add_vec("lost_wait",         1, 0, 1,  0,  0,  1,  0,  1, 0);
        add_vec("lost_wait_stable",  7, 0, 1,  0,  0,  1,  0,  1, 0);
        add_vec("relocked",          1, 0, 1,  0,  1,  0,  0,  1, 0);
        add_vec("drop_in_sync",      2, 0, 0,  0,  1,  0,  0,  1, 0);
        add_vec("drop_reassert",     1, 0, 0,  1,  0,  1,  0,  1, 0);
        add_vec("try1_wait",        16, 0, 0,  0,  0,  1,  0,  1, 0);
        add_vec("try1_before_to",   99, 0, 0,  0,  0,  1,  0,  1, 0);
        add_vec("try2_assert",       1, 0, 0,  1,  0,  1,  0,  1, 1);
        add_vec("try2_before_to",  115, 0, 0,  0,  0,  1,  0,  1, 1);
        add_vec("try3_assert",       1, 0, 0,  1,  0,  1,  0,  1, 2);
        add_vec("try3_before_to",  115, 0, 0,  0,  0,  1,  0,  1, 2);
        add_vec("fail_entry",        1, 0, 0,  0,  0,  0,  1,  1, 3);
        add_vec("fail_terminal",    20, 0, 0,  0,  0,  0,  1,  1, 3);
        add_vec("fail_restart",      1, 1, 0,  1,  0,  1,  0,  1, 0);
        add_vec("restart_asrt_end", 15, 0, 0,  1,  0,  1,  0,  1, 0);
        add_vec("restart_wait",      1, 0, 0,  0,  0,  1,  0,  1, 0);
        add_vec("glitch_run5",       5, 0, 1,  0,  0,  1,  0,  1, 0);
        add_vec("glitch_low",        1, 0, 0,  0,  0,  1,  0,  1, 0);
        add_vec("glitch_no_early",   4, 0, 1,  0,  0,  1,  0,  1, 0);
        add_vec("glitch_run7",       5, 0, 1,  0,  0,  1,  0,  1, 0);
        add_vec("glitch_ready",      1, 0, 1,  0,  1,  0,  0,  1, 0);
        add_vec("ready_start",       1, 1, 1,  1,  0,  1,  0,  1, 0);

        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        if_a.start  = 1'b0;
        if_a.locked = 1'b0;
        if_b.start  = 1'b0;
        if_b.locked = 1'b0;

        repeat (3) @(negedge clk);
        check("a_reset_state", get_obs(1'b0), mk(0, 0, 0, 0, 0, 0));
        check("b_reset_state", get_obs(1'b1), mk(0, 0, 0, 0, 0, 0));
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if_a.start  = vecs[i].start;
            if_a.locked = vecs[i].locked;
            sb_q.push_back('{name: vecs[i].name, exp: vecs[i].exp});
            repeat (vecs[i].cycles) @(negedge clk);
            e = sb_q.pop_front();
            check(e.name, get_obs(1'b0), e.exp);
        end
        if_a.start = 1'b0;

        // DUT A: asynchronous reset in the middle of ASSERT, then auto restart.
        @(negedge clk);
        #2 rst_a_n = 1'b0;
        #1 check("a_async_reset", get_obs(1'b0), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        check("a_restart_assert", get_obs(1'b0), mk(1, 0, 1, 0, 0, 0));
        pulse_len(1'b0, len);
        check_val("a_restart_pulse_len", len, 16);

        // DUT A: lock loss and start landing on the same READY cycle.
        n = 0;
        while (!if_a.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_again", get_obs(1'b0), mk(0, 1, 0, 0, 0, 0));
        if_a.locked = 1'b0;
        repeat (2) @(negedge clk);
        if_a.start = 1'b1;
        check("a_before_simul", get_obs(1'b0), mk(0, 1, 0, 0, 0, 0));
        @(negedge clk);
        if_a.start = 1'b0;
        check("a_simul_loss_start", get_obs(1'b0), mk(1, 0, 1, 0, 1, 0));

        // DUT B: nothing happens without start.
        check("b_idle_no_start", get_obs(1'b1), mk(0, 0, 0, 0, 0, 0));
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        check("b_start_assert", get_obs(1'b1), mk(1, 0, 1, 0, 0, 0));

        // DUT B: a start during ASSERT must not stretch the pulse.
        len = 1;
        @(negedge clk);
        while (if_b.dci_rst && len < 200) begin
            len++;
            if_b.start = (len == 4);
            @(negedge clk);
        end
        if_b.start = 1'b0;
        check_val("b_pulse_len_start_ignored", len, 16);
        check("b_wait_after_pulse", get_obs(1'b1), mk(0, 0, 1, 0, 0, 0));

        // DUT B: reset mid-sequence returns to IDLE and waits for start again.
        #2 rst_b_n = 1'b0;
        #1 check("b_async_reset", get_obs(1'b1), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_b_n = 1'b1;
        repeat (10) @(negedge clk);
        check("b_idle_after_reset", get_obs(1'b1), mk(0, 0, 0, 0, 0, 0));
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        pulse_len(1'b1, len);
        check_val("b_pulse_len_after_reset", len, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
